// File: rtl/tb_status_pkg.sv
// Shared definitions for the testbench status peripheral: register offsets,
// register index enum, default magic constants and the offset decoder.
// Optional watchdog register is compiled in when TB_STATUS_WDOG_EN is defined.
package tb_status_pkg;

    // Byte offsets inside the 32-byte peripheral window
    localparam logic [4:0] OFF_STDOUT = 5'h00;
    localparam logic [4:0] OFF_EXIT   = 5'h04;
    localparam logic [4:0] OFF_TEST   = 5'h08;
    localparam logic [4:0] OFF_CYC_LO = 5'h0C;
    localparam logic [4:0] OFF_CYC_HI = 5'h10;
    localparam logic [4:0] OFF_WDOG   = 5'h14;

    // Default configuration values
    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1000_0000;
    localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'd123456789;
    localparam logic [31:0] DEFAULT_FAIL_MAGIC = 32'd1;

    typedef enum logic [2:0] {
        REG_STDOUT = 3'd0,
        REG_EXIT   = 3'd1,
        REG_TEST   = 3'd2,
        REG_CYC_LO = 3'd3,
        REG_CYC_HI = 3'd4,
        REG_WDOG   = 3'd5,
        REG_NONE   = 3'd7
    } reg_idx_e;

    // Map a word index (byte offset bits [4:2]) to a register; gaps are REG_NONE
    function automatic reg_idx_e decode_offset(input logic [2:0] word_idx);
        reg_idx_e idx;
        case (word_idx)
            OFF_STDOUT[4:2]: idx = REG_STDOUT;
            OFF_EXIT[4:2]:   idx = REG_EXIT;
            OFF_TEST[4:2]:   idx = REG_TEST;
            OFF_CYC_LO[4:2]: idx = REG_CYC_LO;
            OFF_CYC_HI[4:2]: idx = REG_CYC_HI;
`ifdef TB_STATUS_WDOG_EN
            OFF_WDOG[4:2]:   idx = REG_WDOG;
`endif
            default:         idx = REG_NONE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/tb_status_periph_if.sv
// Core data bus seen by the status peripheral: request/grant handshake
// plus a one-cycle-later response.
interface tb_status_periph_if;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/tb_status_fifo.sv
// Small synchronous FIFO used to buffer stdout characters.
// DEPTH must be a power of two (>=2) so the pointers wrap naturally.
// Head data reads as zero while the FIFO is empty.
module tb_status_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1'b1);
    localparam logic [AW:0]    CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == {(AW+1){1'b0}});
    assign data_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/tb_status_periph.sv
// Memory-mapped testbench status peripheral: pass/fail/exit flags polled by
// the simulation top, a stdout character FIFO and a coherent 64-bit cycle
// counter. Define TB_STATUS_WDOG_EN to add the WDOG down-counter register.
module tb_status_periph
    import tb_status_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int unsigned STDOUT_DEPTH = 16,
    parameter logic [31:0] PASS_MAGIC   = DEFAULT_PASS_MAGIC,
    parameter logic [31:0] FAIL_MAGIC   = DEFAULT_FAIL_MAGIC
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tb_status_periph_if.slave    bus,
    output logic                 stdout_valid_o,
    output logic [7:0]           stdout_char_o,
    input  logic                 stdout_ready_i,
    output logic                 tests_passed_o,
    output logic                 tests_failed_o,
    output logic                 exit_valid_o,
    output logic [31:0]          exit_value_o
);
    reg_idx_e    reg_idx_s;
    logic        in_window_s;
    logic        stdout_wr_s;
    logic        gnt_s;
    logic        wr_en_s;
    logic        rd_en_s;
    logic        push_s;
    logic        pop_s;
    logic        exit_wr_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [7:0]  fifo_head_s;
    logic        unused_s;

    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;
    logic        passed_q, passed_d;
    logic        failed_q, failed_d;
    logic        exit_valid_q, exit_valid_d;
    logic [31:0] exit_value_q, exit_value_d;
`ifdef TB_STATUS_WDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_wr_s;
    logic        wdog_fire_s;
`endif

    // Byte-enable upper lanes and address byte bits carry no meaning here
    assign unused_s = ^{bus.data_be[3:1], bus.data_addr[1:0]};

    // Address decode, grant (stalls STDOUT writes while the FIFO is full)
    always_comb begin
        in_window_s = (bus.data_addr[31:5] == BASE_ADDR[31:5]);
        if (in_window_s) begin
            reg_idx_s = decode_offset(bus.data_addr[4:2]);
        end else begin
            reg_idx_s = REG_NONE;
        end
        stdout_wr_s = bus.data_req & bus.data_we & (reg_idx_s == REG_STDOUT);
        gnt_s       = bus.data_req & ~(stdout_wr_s & fifo_full_s);
        wr_en_s     = gnt_s & bus.data_we;
        rd_en_s     = gnt_s & ~bus.data_we;
        push_s      = wr_en_s & (reg_idx_s == REG_STDOUT) & bus.data_be[0];
        exit_wr_s   = wr_en_s & (reg_idx_s == REG_EXIT);
        pop_s       = ~fifo_empty_s & stdout_ready_i;
    end

    tb_status_fifo #(
        .DEPTH (STDOUT_DEPTH),
        .WIDTH (8)
    ) u_stdout_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .data_i  (bus.data_wdata[7:0]),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

`ifdef TB_STATUS_WDOG_EN
    // Watchdog: load on write, count down to zero, fire on the 1->0 step
    always_comb begin
        wdog_wr_s = wr_en_s & (reg_idx_s == REG_WDOG);
        if (wdog_wr_s) begin
            wdog_d = bus.data_wdata;
        end else if (wdog_q != 32'd0) begin
            wdog_d = wdog_q - 32'd1;
        end else begin
            wdog_d = wdog_q;
        end
        wdog_fire_s = (wdog_q == 32'd1) & ~wdog_wr_s & ~exit_valid_q;
    end
`endif

    // Response and read data; a CYC_LO read snapshots the high word
    always_comb begin
        rvalid_d = gnt_s;
        rdata_d  = 32'h0000_0000;
        shadow_d = shadow_q;
        cycle_d  = cycle_q + 64'd1;
        if (rd_en_s) begin
            case (reg_idx_s)
                REG_CYC_LO: begin
                    rdata_d  = cycle_q[31:0];
                    shadow_d = cycle_q[63:32];
                end
                REG_CYC_HI: rdata_d = shadow_q;
`ifdef TB_STATUS_WDOG_EN
                REG_WDOG:   rdata_d = wdog_q;
`endif
                default:    rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Sticky pass/fail flags and first-wins exit code
    always_comb begin
        passed_d     = passed_q;
        failed_d     = failed_q;
        exit_valid_d = exit_valid_q;
        exit_value_d = exit_value_q;
        if (wr_en_s && (reg_idx_s == REG_TEST)) begin
            if (bus.data_wdata == PASS_MAGIC) begin
                passed_d = 1'b1;
            end else begin
                passed_d = passed_q;
            end
            if (bus.data_wdata == FAIL_MAGIC) begin
                failed_d = 1'b1;
            end else begin
                failed_d = failed_q;
            end
        end else begin
            passed_d = passed_q;
            failed_d = failed_q;
        end
        if (exit_wr_s && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_value_d = bus.data_wdata;
        end
`ifdef TB_STATUS_WDOG_EN
        else if (wdog_fire_s) begin
            exit_valid_d = 1'b1;
            exit_value_d = 32'hFFFF_FFFF;
            failed_d     = 1'b1;
        end
`endif
        else begin
            exit_valid_d = exit_valid_q;
            exit_value_d = exit_value_q;
        end
    end

    // Peripheral state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            cycle_q      <= 64'd0;
            shadow_q     <= 32'h0000_0000;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= 32'h0000_0000;
`ifdef TB_STATUS_WDOG_EN
            wdog_q       <= 32'd0;
`endif
        end else begin
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            cycle_q      <= cycle_d;
            shadow_q     <= shadow_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
`ifdef TB_STATUS_WDOG_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign bus.data_gnt    = gnt_s;
    assign bus.data_rvalid = rvalid_q;
    assign bus.data_rdata  = rdata_q;
    assign stdout_valid_o  = ~fifo_empty_s;
    assign stdout_char_o   = fifo_head_s;
    assign tests_passed_o  = passed_q;
    assign tests_failed_o  = failed_q;
    assign exit_valid_o    = exit_valid_q;
    assign exit_value_o    = exit_value_q;
endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph: directed scenarios with literal
// expectations plus randomized bus traffic checked every cycle against a
// behavioural model (character queue, flags, cycle count).
module tb_tb_status_periph;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] PASSM = 32'd123456789;
    localparam logic [31:0] FAILM = 32'd1;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stdout_ready = 1'b0;
    logic        stdout_valid;
    logic [7:0]  stdout_char;
    logic        tests_passed, tests_failed, exit_valid;
    logic [31:0] exit_value;

    tb_status_periph_if bus_if ();

    tb_status_periph dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus_if),
        .stdout_valid_o (stdout_valid),
        .stdout_char_o  (stdout_char),
        .stdout_ready_i (stdout_ready),
        .tests_passed_o (tests_passed),
        .tests_failed_o (tests_failed),
        .exit_valid_o   (exit_valid),
        .exit_value_o   (exit_value)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pops_seen = 0;
    bit chk_en = 1'b0;
    bit rand_ready = 1'b0;
    int ready_pct = 50;

    // behavioural model state
    byte unsigned mq[$];
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_pass = 1'b0, m_fail = 1'b0, m_exv = 1'b0;
    logic [31:0] m_exval = 32'h0;
    logic [63:0] m_cyc = 64'h0;
    logic [31:0] m_shadow = 32'h0;
    logic [31:0] m_wdog = 32'h0;
    bit          m_cyc_load = 1'b0;
    logic [63:0] m_cyc_val = 64'h0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] offs(input logic [31:0] a);
        return (a - BASE) & 32'hFFFF_FFFC;
    endfunction

    function automatic logic exp_gnt();
        bit st;
        st = bus_if.data_we && in_win(bus_if.data_addr) && (offs(bus_if.data_addr) == 32'd0);
        return bus_if.data_req && !(st && mq.size() == DEPTH);
    endfunction

    // model: advances on every clock edge, resets with rst_n
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_rvalid = 1'b0; m_rdata = 32'h0; m_pass = 1'b0; m_fail = 1'b0;
            m_exv = 1'b0; m_exval = 32'h0; m_cyc = 64'h0; m_shadow = 32'h0; m_wdog = 32'h0;
        end else begin : step
            logic g, rd, wr, ex_wr, wd_wr, fire, push, pop;
            logic [31:0] a, o, d, nrd;
            logic [63:0] cur;
            a = bus_if.data_addr; d = bus_if.data_wdata; o = offs(a);
            cur = m_cyc_load ? m_cyc_val : m_cyc;
            g = exp_gnt();
            rd = g && !bus_if.data_we && in_win(a);
            wr = g && bus_if.data_we && in_win(a);
            nrd = 32'h0;
            if (rd && o == 32'h0C) begin nrd = cur[31:0]; m_shadow = cur[63:32]; end
            else if (rd && o == 32'h10) nrd = m_shadow;
`ifdef TB_STATUS_WDOG_EN
            else if (rd && o == 32'h14) nrd = m_wdog;
`endif
            push  = wr && o == 32'h00 && bus_if.data_be[0];
            ex_wr = wr && o == 32'h04;
            if (wr && o == 32'h08 && d == PASSM) m_pass = 1'b1;
            if (wr && o == 32'h08 && d == FAILM) m_fail = 1'b1;
            wd_wr = 1'b0;
            fire  = 1'b0;
`ifdef TB_STATUS_WDOG_EN
            wd_wr = wr && o == 32'h14;
            fire  = (m_wdog == 32'd1) && !wd_wr && !m_exv;
            if (wd_wr) m_wdog = d;
            else if (m_wdog != 32'd0) m_wdog = m_wdog - 32'd1;
`endif
            if (ex_wr && !m_exv) begin m_exv = 1'b1; m_exval = d; end
            else if (fire) begin m_exv = 1'b1; m_exval = 32'hFFFF_FFFF; m_fail = 1'b1; end
            pop = (mq.size() != 0) && stdout_ready;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d[7:0]);
            m_rvalid = g; m_rdata = nrd;
            m_cyc = cur + 64'd1;
        end
    end

    // compare process: every cycle, away from the clock edge
    initial forever begin
        @(negedge clk); #2;
        if (chk_en) begin
            check("gnt", bus_if.data_gnt, exp_gnt());
            check("rvalid", bus_if.data_rvalid, m_rvalid);
            check("rdata", bus_if.data_rdata, m_rdata);
            check("stdout_valid", stdout_valid, mq.size() != 0);
            check("stdout_char", stdout_char, (mq.size() != 0) ? mq[0] : 8'h00);
            check("passed", tests_passed, m_pass);
            check("failed", tests_failed, m_fail);
            check("exit_valid", exit_valid, m_exv);
            check("exit_value", exit_value, m_exval);
            if (stdout_valid && stdout_ready) pops_seen++;
        end
    end

    task automatic rnd_ready();
        if (rand_ready) stdout_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic bus_op(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus_if.data_req = 1'b1; bus_if.data_addr = a; bus_if.data_we = w;
        bus_if.data_be = b; bus_if.data_wdata = d;
        for (int i = 0; i < 300 && !done; i++) begin
            if (i != 0) @(negedge clk);
            rnd_ready();
            #3;
            if (bus_if.data_gnt === 1'b1) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL bus_op_timeout: got no grant expected grant for addr %h", a);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.data_req = 1'b0;
            rnd_ready();
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk); bus_if.data_req = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        bus_if.data_req = 1'b0; bus_if.data_addr = 32'h0; bus_if.data_we = 1'b0;
        bus_if.data_be = 4'h0; bus_if.data_wdata = 32'h0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_exit_valid", exit_valid, 1'b0);
        check("rst_stdout_valid", stdout_valid, 1'b0);
        check("rst_rvalid", bus_if.data_rvalid, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // 'A','B','C' with a ready consumer
        stdout_ready = 1'b1;
        bus_op(BASE, 1'b1, 4'h1, 32'h41); @(posedge clk); #1;
        check("abc_char0", stdout_char, 8'h41); check("abc_rv0", bus_if.data_rvalid, 1'b1);
        bus_op(BASE, 1'b1, 4'h1, 32'h42); @(posedge clk); #1;
        check("abc_char1", stdout_char, 8'h42); check("abc_rv1", bus_if.data_rvalid, 1'b1);
        bus_op(BASE, 1'b1, 4'h1, 32'h43); @(posedge clk); #1;
        check("abc_char2", stdout_char, 8'h43); check("abc_rv2", bus_if.data_rvalid, 1'b1);
        idle(3);

        // fill FIFO, 17th write stalls until one pop
        @(negedge clk); stdout_ready = 1'b0; pops_seen = 0;
        for (int i = 0; i < 16; i++) bus_op(BASE, 1'b1, 4'hF, 32'h60 + 32'(i));
        @(negedge clk);
        bus_if.data_addr = BASE; bus_if.data_we = 1'b1; bus_if.data_wdata = 32'h70;
        for (int i = 0; i < 3; i++) begin
            #3; check("full_stall", bus_if.data_gnt, 1'b0); @(negedge clk);
        end
        stdout_ready = 1'b1; #3; check("full_pop_cycle", bus_if.data_gnt, 1'b0);
        @(negedge clk); stdout_ready = 1'b0; #3; check("after_pop_gnt", bus_if.data_gnt, 1'b1);
        @(negedge clk); bus_if.data_req = 1'b0; stdout_ready = 1'b1;
        idle(20);
        check("pops_total", pops_seen, 17);
        check("drained", stdout_valid, 1'b0);

        // read-only / unmapped corners
        bus_op(BASE, 1'b0, 4'hF, 32'h0); @(posedge clk); #1;
        check("rd_stdout_zero", bus_if.data_rdata, 32'h0);
        bus_op(BASE + 32'h20, 1'b0, 4'hF, 32'h0); @(posedge clk); #1;
        check("rd_outside_zero", bus_if.data_rdata, 32'h0); check("rd_outside_rv", bus_if.data_rvalid, 1'b1);

        // TEST pass magic then a junk value
        bus_op(BASE + 32'h08, 1'b1, 4'hF, PASSM); @(posedge clk); #1;
        check("pass_set", tests_passed, 1'b1);
        bus_op(BASE + 32'h08, 1'b1, 4'hF, 32'd7); idle(3);
        check("pass_sticky", tests_passed, 1'b1); check("fail_clear", tests_failed, 1'b0);

        // EXIT first-wins, partial byte enable on the second
        bus_op(BASE + 32'h04, 1'b1, 4'hF, 32'd5); @(posedge clk); #1;
        check("exit_valid", exit_valid, 1'b1); check("exit_val5", exit_value, 32'd5);
        bus_op(BASE + 32'h04, 1'b1, 4'h3, 32'd9); idle(3);
        check("exit_held", exit_value, 32'd5);

        // coherent 64-bit read across a low-word wrap
        @(negedge clk);
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        m_cyc_val = 64'h0000_0000_FFFF_FFFF; m_cyc_load = 1'b1;
        bus_if.data_req = 1'b1; bus_if.data_addr = BASE + 32'h0C; bus_if.data_we = 1'b0;
        @(negedge clk);
        release dut.cycle_q;
        bus_if.data_addr = BASE + 32'h10;
        #3; check("cyc_lo_wrap", bus_if.data_rdata, 32'hFFFF_FFFF);
        @(negedge clk); bus_if.data_req = 1'b0;
        #3; check("cyc_hi_shadow", bus_if.data_rdata, 32'h0000_0000);
        m_cyc_load = 1'b0;

        // reset in the middle of a granted read: no response afterwards
        @(negedge clk);
        bus_if.data_req = 1'b1; bus_if.data_addr = BASE + 32'h0C; bus_if.data_we = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk); bus_if.data_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; check("rst_mid_rv", bus_if.data_rvalid, 1'b0);
        check("rst_mid_exit", exit_valid, 1'b0);

`ifdef TB_STATUS_WDOG_EN
        bus_op(BASE + 32'h14, 1'b1, 4'hF, 32'd10);
        @(posedge clk); @(negedge clk); bus_if.data_req = 1'b0;
        repeat (9) @(posedge clk);
        #1; check("wdog_early", tests_failed, 1'b0);
        @(posedge clk); #1;
        check("wdog_fail", tests_failed, 1'b1); check("wdog_exit", exit_value, 32'hFFFF_FFFF);
        reset_pulse();
`endif

        // randomized traffic
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            if (i == 500 || i == 1000) reset_pulse();
            ready_pct = (i < 750) ? 20 : 80;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE + 32'd32 + 32'($urandom_range(0, 7)) * 32'd4;
                default: a = BASE + 32'($urandom_range(0, 7)) * 32'd4;
            endcase
            case ($urandom_range(0, 7))
                0:       d = PASSM;
                1:       d = FAILM;
                2:       d = 32'($urandom_range(1, 40));
                default: d = $urandom;
            endcase
            bus_op(a, ($urandom_range(0, 2) != 0), 4'($urandom), d);
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0; stdout_ready = 1'b1;
        idle(DEPTH + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
